// File: rtl/zmem_pkg.sv
// zmem_pkg: shared types and constants for the zephyr memory responder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package zmem_pkg;

   // Responder control states
   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_IDLE    = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } zmem_state_e;

   // Default geometry of the zephyr word store
   localparam int ZMEM_DEPTH  = 16;
   localparam int ZMEM_ADDR_W = 4;
   localparam int ZMEM_WIDTH  = 8;

   // Even parity over a data word; callers zero-extend narrower words,
   // which leaves the XOR unchanged.
   function automatic logic zmem_parity(input logic [63:0] dat);
      return ^dat;
   endfunction

endpackage : zmem_pkg

// File: rtl/zmem_array.sv
// zmem_array: DEPTH x DW word store, synchronous write port, asynchronous read port.
// Latency: write lands on the clock edge; read data is combinational from the address.
// Backpressure: none; the owner decides when to write and when to sample reads.
module zmem_array #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int DW     = 8
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DW-1:0]     wr_dat_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DW-1:0]     rd_dat_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Storage is not reset here: the responder clears it word by word in INIT
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_addr_i];

endmodule : zmem_array

// File: rtl/zmem_resp.sv
// zmem_resp: handshaked 16x8 memory responder (fetch/LOAD/STR), cleared by an INIT sweep.
// Latency: request accepted at edge N -> RSP_VALID high after edge N+1+READ_WAIT.
// Backpressure: one request outstanding; response held until RSP_READY, REQ_READY low meanwhile.
// Optional feature macro: ZMEM_PARITY_EN (per-word even parity, error injection, RSP_ERR on reads).
module zmem_resp
   import zmem_pkg::*;
#(
   parameter int DEPTH     = ZMEM_DEPTH,
   parameter int ADDR_W    = ZMEM_ADDR_W,
   parameter int WIDTH     = ZMEM_WIDTH,
   parameter int READ_WAIT = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [WIDTH-1:0]  REQ_WDATA,
   input  logic              REQ_ERR_INJ,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [WIDTH-1:0]  RSP_DATA,
   output logic              RSP_ERR
);

`ifdef ZMEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int MEM_W     = WIDTH + PAR_W;
   // Counter preload for WAIT; unused when READ_WAIT is zero
   localparam int WAIT_LOAD = (READ_WAIT > 0) ? (READ_WAIT - 1) : 0;

   zmem_state_e        state_q;
   logic [ADDR_W-1:0]  init_cnt_q;
   logic [2:0]         wait_cnt_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic               req_ready_q;
   logic               rsp_valid_q;
   logic [WIDTH-1:0]   rsp_data_q;
   logic               rsp_err_q;

   logic               accept;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [MEM_W-1:0]   wr_dat;
   logic [MEM_W-1:0]   rd_dat;
   logic               rd_err;
   logic [WIDTH-1:0]   rsp_data_d;
   logic               rsp_err_d;

   assign accept = (state_q == ST_IDLE) && req_ready_q && REQ_VALID;

   // Write port mux: INIT sweep clears words, otherwise an accepted write lands at the accept edge
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = init_cnt_q;
      wr_dat  = '0;
      if (state_q == ST_INIT) begin
         wr_en = 1'b1;
      end else if (accept && REQ_WE) begin
         wr_en   = 1'b1;
         wr_addr = REQ_ADDR;
`ifdef ZMEM_PARITY_EN
         wr_dat  = {zmem_parity(64'(REQ_WDATA)) ^ REQ_ERR_INJ, REQ_WDATA};
`else
         wr_dat  = REQ_WDATA;
`endif
      end
   end

`ifndef ZMEM_PARITY_EN
   // Error injection has no effect without parity storage
   logic unused_err_inj;
   assign unused_err_inj = REQ_ERR_INJ;
`endif

   zmem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DW     (MEM_W)
   ) u_array (
      .clk_i     (CLK),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_dat_i  (wr_dat),
      .rd_addr_i (addr_q),
      .rd_dat_o  (rd_dat)
   );

   // Parity check of the word addressed by the latched request
   always_comb begin
`ifdef ZMEM_PARITY_EN
      rd_err = rd_dat[WIDTH] ^ zmem_parity(64'(rd_dat[WIDTH-1:0]));
`else
      rd_err = 1'b0;
`endif
   end

   // Response payload: echoed data for writes, stored word for reads
   always_comb begin
      rsp_data_d = rd_dat[WIDTH-1:0];
      rsp_err_d  = rd_err;
      if (we_q) begin
         rsp_data_d = wdata_q;
         rsp_err_d  = 1'b0;
      end
   end

   // Control FSM with registered handshake outputs. RESPOND spends its first
   // cycle capturing the response, so RSP_VALID rises one edge after entry.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + ADDR_W'(1);
               if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= ST_IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  we_q        <= REQ_WE;
                  addr_q      <= REQ_ADDR;
                  wdata_q     <= REQ_WDATA;
                  req_ready_q <= 1'b0;
                  if (READ_WAIT == 0) begin
                     state_q <= ST_RESPOND;
                  end else begin
                     state_q    <= ST_WAIT;
                     wait_cnt_q <= 3'(WAIT_LOAD);
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == 3'd0) begin
                  state_q <= ST_RESPOND;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end
            end
            ST_RESPOND: begin
               if (!rsp_valid_q) begin
                  rsp_data_q  <= rsp_data_d;
                  rsp_err_q   <= rsp_err_d;
                  rsp_valid_q <= 1'b1;
               end else if (RSP_READY) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_INIT;
            end
         endcase
      end
   end

   assign REQ_READY = req_ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_ERR   = rsp_err_q;

endmodule : zmem_resp

// File: tb/tb_zmem_resp.sv
// tb_zmem_resp: directed self-checking bench for zmem_resp (READ_WAIT=0 and READ_WAIT=3 instances).
// Latency: checks accept-to-valid distance and the INIT length.
// Backpressure: holds RSP_READY low with a competing request and checks the response is held.
`timescale 1ns/1ps
module tb_zmem_resp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   // READ_WAIT = 0 instance
   logic       req_valid, req_ready, req_we, req_err_inj;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [7:0] rsp_data;
   // READ_WAIT = 3 instance
   logic       w3_req_valid, w3_req_ready, w3_req_we, w3_req_err_inj;
   logic [3:0] w3_req_addr;
   logic [7:0] w3_req_wdata;
   logic       w3_rsp_valid, w3_rsp_ready, w3_rsp_err;
   logic [7:0] w3_rsp_data;

`ifdef ZMEM_PARITY_EN
   localparam logic PAR_ON = 1'b1;
`else
   localparam logic PAR_ON = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   zmem_resp #(.DEPTH(16), .ADDR_W(4), .WIDTH(8), .READ_WAIT(0)) dut0 (
      .CLK(clk), .RESET(rst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_ERR_INJ(req_err_inj),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err)
   );

   zmem_resp #(.DEPTH(16), .ADDR_W(4), .WIDTH(8), .READ_WAIT(3)) dut3 (
      .CLK(clk), .RESET(rst),
      .REQ_VALID(w3_req_valid), .REQ_READY(w3_req_ready), .REQ_WE(w3_req_we),
      .REQ_ADDR(w3_req_addr), .REQ_WDATA(w3_req_wdata), .REQ_ERR_INJ(w3_req_err_inj),
      .RSP_VALID(w3_rsp_valid), .RSP_READY(w3_rsp_ready), .RSP_DATA(w3_rsp_data), .RSP_ERR(w3_rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until dut0 raises REQ_READY after reset release
   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         step();
         n++;
      end
      check(tag, n, 16);
   endtask

   // One complete request/response on dut0; RSP_READY raised only once valid is seen
   task automatic do_req(input string tag, input logic we, input logic [3:0] addr,
                         input logic [7:0] wd, input logic inj,
                         output logic [7:0] d, output logic e, output int lat);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         step();
         n++;
      end
      check({tag, "_rdy"}, req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_err_inj = inj;
      step();
      req_valid = 1'b0; req_we = 1'b0; req_err_inj = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         step();
         lat++;
      end
      d = rsp_data;
      e = rsp_err;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       e;
      int         lat;
      int         n;
      logic       stable;

      rst = 1'b1;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_err_inj = 0; rsp_ready = 0;
      w3_req_valid = 0; w3_req_we = 0; w3_req_addr = 0; w3_req_wdata = 0; w3_req_err_inj = 0;
      w3_rsp_ready = 0;
      step(); step(); step();

      // Reset state
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      rst = 1'b0;
      wait_init("init_len");

      // Every word reads back zero after INIT
      for (int a = 0; a < 16; a++) begin
         do_req("init_rd", 1'b0, 4'(a), 8'h00, 1'b0, d, e, lat);
         check($sformatf("init_rd%0d_data", a), d, 8'h00);
         check($sformatf("init_rd%0d_err", a), e, 0);
      end

      // Write then read with READ_WAIT=0
      do_req("wr3", 1'b1, 4'd3, 8'hA5, 1'b0, d, e, lat);
      check("wr3_echo", d, 8'hA5);
      check("wr3_lat", lat, 1);
      do_req("rd3", 1'b0, 4'd3, 8'h00, 1'b0, d, e, lat);
      check("rd3_data", d, 8'hA5);
      check("rd3_lat", lat, 1);
      check("idle_after_hs_valid", rsp_valid, 0);
      check("idle_after_hs_ready", req_ready, 1);

      // READ_WAIT=3 instance: write then read address 3, both with latency 4
      for (int i = 0; i < 2; i++) begin
         logic rdy_seen;
         n = 0;
         while (!w3_req_ready && n < 100) begin
            step();
            n++;
         end
         check("w3_rdy", w3_req_ready, 1);
         w3_req_valid = 1'b1; w3_req_we = (i == 0); w3_req_addr = 4'd3; w3_req_wdata = 8'h5A;
         step();
         w3_req_valid = 1'b0; w3_req_we = 1'b0; w3_req_wdata = 8'h00;
         lat = 0;
         rdy_seen = 1'b0;
         while (!w3_rsp_valid && lat < 100) begin
            if (w3_req_ready) rdy_seen = 1'b1;
            step();
            lat++;
         end
         check($sformatf("w3_lat%0d", i), lat, 4);
         check($sformatf("w3_rdy_low%0d", i), rdy_seen | w3_req_ready, 0);
         check($sformatf("w3_data%0d", i), w3_rsp_data, 8'h5A);
         w3_rsp_ready = 1'b1;
         step();
         w3_rsp_ready = 1'b0;
      end

      // Backpressure: response held 10 cycles while a competing request waits
      do_req("wr5", 1'b1, 4'd5, 8'h3C, 1'b0, d, e, lat);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
      step();
      req_addr = 4'd3;
      n = 0;
      while (!rsp_valid && n < 100) begin
         step();
         n++;
      end
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (!rsp_valid || rsp_data !== 8'h3C || req_ready) stable = 1'b0;
         step();
      end
      check("bp_stable", stable, 1);
      check("bp_data", rsp_data, 8'h3C);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("bp_release_valid", rsp_valid, 0);
      check("bp_release_ready", req_ready, 1);
      step(); step();
      check("bp_no_ghost_rsp", rsp_valid, 0);

      // Parity injection and repair
      do_req("par_wr", 1'b1, 4'd7, 8'h0F, 1'b1, d, e, lat);
      check("par_wr_err", e, 0);
      do_req("par_rd", 1'b0, 4'd7, 8'h00, 1'b0, d, e, lat);
      check("par_rd_data", d, 8'h0F);
      check("par_rd_err", e, PAR_ON);
      do_req("par_rewr", 1'b1, 4'd7, 8'h0F, 1'b0, d, e, lat);
      do_req("par_rerd", 1'b0, 4'd7, 8'h00, 1'b0, d, e, lat);
      check("par_rerd_data", d, 8'h0F);
      check("par_rerd_err", e, 0);

      // Reset while a response is pending
      do_req("mr_wr", 1'b1, 4'd3, 8'h77, 1'b0, d, e, lat);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
      step();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 100) begin
         step();
         n++;
      end
      check("mr_pending_data", rsp_data, 8'h77);
      rst = 1'b1;
      #1;
      check("mr_valid_drop", rsp_valid, 0);
      check("mr_data_clr", rsp_data, 0);
      check("mr_ready_low", req_ready, 0);
      step();
      rst = 1'b0;
      wait_init("mr_init_len");
      do_req("mr_rd", 1'b0, 4'd3, 8'h00, 1'b0, d, e, lat);
      check("mr_rd_data", d, 8'h00);
      check("mr_rd_err", e, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit in case the flow above stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000ns");
      $fatal(1);
   end

endmodule : tb_zmem_resp
